// File: rtl/tank_pkg.sv
// Shared tank-game constants: map geometry, direction encoding, keycodes.
// Both the tank movement logic and the shell controller import this package.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_COOL = 2'd2
    } shell_state_t;

    localparam int MAP_W      = 20;
    localparam int MAP_H      = 15;
    localparam int MAP_TILES  = MAP_W * MAP_H;
    localparam int TILE_SHIFT = 5;

    localparam logic [7:0] KEY_P1_UP    = 8'h1A;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h16;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h04;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h07;
    localparam logic [7:0] KEY_P1_FIRE  = 8'h2C;

    localparam logic [7:0] KEY_P2_UP    = 8'h52;
    localparam logic [7:0] KEY_P2_DOWN  = 8'h51;
    localparam logic [7:0] KEY_P2_LEFT  = 8'h50;
    localparam logic [7:0] KEY_P2_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_P2_FIRE  = 8'h28;

    // Returns {valid, dir}; valid=0 means the key is not one of this player's arrows.
    function automatic logic [2:0] decode_dir(input logic p1, input logic [7:0] key);
        logic [2:0] r;
        r = 3'b000;
        if (p1) begin
            if (key == KEY_P1_UP)         r = {1'b1, DIR_UP};
            else if (key == KEY_P1_DOWN)  r = {1'b1, DIR_DOWN};
            else if (key == KEY_P1_LEFT)  r = {1'b1, DIR_LEFT};
            else if (key == KEY_P1_RIGHT) r = {1'b1, DIR_RIGHT};
        end else begin
            if (key == KEY_P2_UP)         r = {1'b1, DIR_UP};
            else if (key == KEY_P2_DOWN)  r = {1'b1, DIR_DOWN};
            else if (key == KEY_P2_LEFT)  r = {1'b1, DIR_LEFT};
            else if (key == KEY_P2_RIGHT) r = {1'b1, DIR_RIGHT};
        end
        return r;
    endfunction

    // Indices past the last tile read as solid so a malformed position can never escape the map.
    function automatic logic wall_at(input logic [MAP_TILES-1:0] walls, input logic [8:0] idx);
        logic solid;
        solid = 1'b1;
        if (int'(idx) < MAP_TILES) solid = walls[idx];
        return solid;
    endfunction

endpackage

// File: rtl/tile_step.sv
// One-tile step on the 20x15 grid in a given direction, with edge detection
// and the row-major wall index of the destination tile.
module tile_step
    import tank_pkg::*;
(
    input  logic [4:0] xtile,
    input  logic [4:0] ytile,
    input  dir_t       dir,
    output logic [4:0] next_xtile,
    output logic [4:0] next_ytile,
    output logic       off_grid,
    output logic [8:0] index
);

    always_comb begin
        next_xtile = xtile;
        next_ytile = ytile;
        off_grid   = 1'b0;
        unique case (dir)
            DIR_UP: begin
                if (ytile == 5'd0) off_grid = 1'b1;
                else               next_ytile = ytile - 5'd1;
            end
            DIR_DOWN: begin
                if (ytile >= 5'(MAP_H - 1)) off_grid = 1'b1;
                else                        next_ytile = ytile + 5'd1;
            end
            DIR_LEFT: begin
                if (xtile == 5'd0) off_grid = 1'b1;
                else               next_xtile = xtile - 5'd1;
            end
            DIR_RIGHT: begin
                if (xtile >= 5'(MAP_W - 1)) off_grid = 1'b1;
                else                        next_xtile = xtile + 5'd1;
            end
        endcase
        index = 9'(next_ytile) * 9'(MAP_W) + 9'(next_xtile);
    end

endmodule

// File: rtl/tank_shell.sv
// Per-tank projectile controller: tracks facing, launches on a fire-key edge,
// walks the shell one tile per STEP_FRAMES, then enforces a cooldown.
module tank_shell
    import tank_pkg::*;
#(
    parameter int STEP_FRAMES     = 4,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 player,
    input  logic [7:0]           keycode,
    input  logic [MAP_TILES-1:0] map_wall,
    input  logic [9:0]           OwnX,
    input  logic [9:0]           OwnY,
    input  logic [9:0]           EnemyX,
    input  logic [9:0]           EnemyY,
    output logic [9:0]           ShellX,
    output logic [9:0]           ShellY,
    output logic                 shell_active,
    output logic                 hit,
    output logic [1:0]           facing
);

    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_FRAMES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_FRAMES - 1);

    shell_state_t  state_q, state_d;
    dir_t          facing_q, facing_d;
    dir_t          shell_dir_q, shell_dir_d;
    logic [4:0]    shell_x_q, shell_x_d;
    logic [4:0]    shell_y_q, shell_y_d;
    logic          active_q, active_d;
    logic          hit_q, hit_d;
    logic [7:0]    prev_key_q, prev_key_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;

    logic [4:0] own_xt, own_yt, enemy_xt, enemy_yt;
    logic [4:0] launch_x, launch_y, adv_x, adv_y;
    logic [8:0] launch_idx, adv_idx;
    logic       launch_off, adv_off;
    logic       launch_blocked, adv_blocked;
    logic [7:0] fire_code;
    logic       fire_edge;
    logic [2:0] key_dir;

    assign own_xt   = OwnX[9:TILE_SHIFT];
    assign own_yt   = OwnY[9:TILE_SHIFT];
    assign enemy_xt = EnemyX[9:TILE_SHIFT];
    assign enemy_yt = EnemyY[9:TILE_SHIFT];

    // Launch looks one tile ahead of our own tank; advance looks ahead of the shell.
    tile_step u_launch_step (
        .xtile      (own_xt),
        .ytile      (own_yt),
        .dir        (facing_q),
        .next_xtile (launch_x),
        .next_ytile (launch_y),
        .off_grid   (launch_off),
        .index      (launch_idx)
    );

    tile_step u_advance_step (
        .xtile      (shell_x_q),
        .ytile      (shell_y_q),
        .dir        (shell_dir_q),
        .next_xtile (adv_x),
        .next_ytile (adv_y),
        .off_grid   (adv_off),
        .index      (adv_idx)
    );

    assign launch_blocked = launch_off || wall_at(map_wall, launch_idx);
    assign adv_blocked    = adv_off || wall_at(map_wall, adv_idx);
    assign fire_code      = player ? KEY_P1_FIRE : KEY_P2_FIRE;
    assign fire_edge      = (keycode == fire_code) && (prev_key_q != fire_code);
    assign key_dir        = decode_dir(player, keycode);

    always_comb begin
        state_d     = state_q;
        facing_d    = facing_q;
        shell_dir_d = shell_dir_q;
        shell_x_d   = shell_x_q;
        shell_y_d   = shell_y_q;
        active_d    = active_q;
        hit_d       = 1'b0;
        prev_key_d  = keycode;
        step_cnt_d  = step_cnt_q;
        cool_cnt_d  = cool_cnt_q;

        if (key_dir[2]) facing_d = dir_t'(key_dir[1:0]);

        case (state_q)
            ST_IDLE: begin
                if (fire_edge) begin
                    if (launch_blocked) begin
                        state_d    = ST_COOL;
                        cool_cnt_d = '0;
                    end else if (launch_x == enemy_xt && launch_y == enemy_yt) begin
                        hit_d      = 1'b1;
                        state_d    = ST_COOL;
                        cool_cnt_d = '0;
                    end else begin
                        shell_x_d   = launch_x;
                        shell_y_d   = launch_y;
                        shell_dir_d = facing_q;
                        active_d    = 1'b1;
                        step_cnt_d  = '0;
                        state_d     = ST_FLY;
                    end
                end
            end
            ST_FLY: begin
                // The enemy driving onto the shell takes priority over stepping.
                if (shell_x_q == enemy_xt && shell_y_q == enemy_yt) begin
                    hit_d      = 1'b1;
                    active_d   = 1'b0;
                    state_d    = ST_COOL;
                    cool_cnt_d = '0;
                end else if (step_cnt_q == STEP_LAST) begin
                    if (adv_blocked) begin
                        active_d   = 1'b0;
                        state_d    = ST_COOL;
                        cool_cnt_d = '0;
                    end else if (adv_x == enemy_xt && adv_y == enemy_yt) begin
                        hit_d      = 1'b1;
                        active_d   = 1'b0;
                        state_d    = ST_COOL;
                        cool_cnt_d = '0;
                    end else begin
                        shell_x_d  = adv_x;
                        shell_y_d  = adv_y;
                        step_cnt_d = '0;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            ST_COOL: begin
                if (cool_cnt_q == COOL_LAST) begin
                    state_d    = ST_IDLE;
                    cool_cnt_d = '0;
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            facing_q    <= player ? DIR_UP : DIR_DOWN;
            shell_dir_q <= DIR_UP;
            shell_x_q   <= '0;
            shell_y_q   <= '0;
            active_q    <= 1'b0;
            hit_q       <= 1'b0;
            prev_key_q  <= 8'h00;
            step_cnt_q  <= '0;
            cool_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            facing_q    <= facing_d;
            shell_dir_q <= shell_dir_d;
            shell_x_q   <= shell_x_d;
            shell_y_q   <= shell_y_d;
            active_q    <= active_d;
            hit_q       <= hit_d;
            prev_key_q  <= prev_key_d;
            step_cnt_q  <= step_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
        end
    end

    assign ShellX       = {shell_x_q, 5'b0};
    assign ShellY       = {shell_y_q, 5'b0};
    assign shell_active = active_q;
    assign hit          = hit_q;
    assign facing       = facing_q;

endmodule

// File: tb/tb_tank_shell.sv
// Directed bench for tank_shell: launch, stepping, walls, cooldown, hits,
// edge-of-map termination and mid-flight reset.
module tb_tank_shell;

    logic         clk;
    logic         Reset;
    logic         player;
    logic [7:0]   keycode;
    logic [299:0] map_wall;
    logic [9:0]   OwnX, OwnY, EnemyX, EnemyY;
    logic [9:0]   ShellX, ShellY;
    logic         shell_active, hit;
    logic [1:0]   facing;

    int n_cmp = 0;
    int n_err = 0;

    tank_shell dut (
        .frame_clk    (clk),
        .Reset        (Reset),
        .player       (player),
        .keycode      (keycode),
        .map_wall     (map_wall),
        .OwnX         (OwnX),
        .OwnY         (OwnY),
        .EnemyX       (EnemyX),
        .EnemyY       (EnemyY),
        .ShellX       (ShellX),
        .ShellY       (ShellY),
        .shell_active (shell_active),
        .hit          (hit),
        .facing       (facing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %-16s observed %0d expected %0d", tag, obs, exp);
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        player   = 1'b1;
        keycode  = 8'h00;
        map_wall = '0;
        OwnX     = 10'd32;
        OwnY     = 10'd416;
        EnemyX   = 10'd608;
        EnemyY   = 10'd448;
        ticks(2);
        chk("rst_active", 32'(shell_active), 0);
        chk("rst_shellx", 32'(ShellX), 0);
        chk("rst_shelly", 32'(ShellY), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_facing_p1", 32'(facing), 0);
        Reset = 1'b0;

        // Launch upward from tile (1,13), then one advance after 4 edges.
        keycode = 8'h2C;
        tick();
        chk("t1_launch_act", 32'(shell_active), 1);
        chk("t1_launch_x", 32'(ShellX), 32);
        chk("t1_launch_y", 32'(ShellY), 384);
        keycode = 8'h00;
        ticks(3);
        chk("t1_hold_y", 32'(ShellY), 384);
        tick();
        chk("t1_adv_y", 32'(ShellY), 352);
        // Turning right mid-flight must not steer the shell.
        keycode = 8'h07;
        tick();
        chk("t1_facing_r", 32'(facing), 3);
        ticks(3);
        chk("t1_latch_x", 32'(ShellX), 32);
        chk("t1_latch_y", 32'(ShellY), 320);
        // Mid-flight reset.
        Reset   = 1'b1;
        keycode = 8'h00;
        tick();
        chk("t6_rst_act", 32'(shell_active), 0);
        chk("t6_rst_x", 32'(ShellX), 0);
        chk("t6_rst_y", 32'(ShellY), 0);
        chk("t6_rst_hit", 32'(hit), 0);
        chk("t6_rst_facing", 32'(facing), 0);
        Reset = 1'b0;

        // Wall right of the tank: fire goes straight to cooldown.
        keycode = 8'h07;
        tick();
        chk("t2_facing", 32'(facing), 3);
        map_wall[13*20+2] = 1'b1;
        keycode = 8'h2C;
        tick();
        chk("t2_blk_act", 32'(shell_active), 0);
        chk("t2_blk_hit", 32'(hit), 0);
        map_wall = '0;
        keycode  = 8'h00;
        ticks(9);
        keycode = 8'h2C;
        tick();
        chk("t2_cool10_act", 32'(shell_active), 0);
        keycode = 8'h00;
        ticks(19);
        keycode = 8'h2C;
        tick();
        chk("t2_cool30_act", 32'(shell_active), 0);
        keycode = 8'h00;
        tick();
        keycode = 8'h2C;
        tick();
        chk("t2_idle_act", 32'(shell_active), 1);
        chk("t2_idle_x", 32'(ShellX), 64);
        chk("t2_idle_y", 32'(ShellY), 416);

        // Fire held: one shell only; re-press during flight is discarded.
        ticks(20);
        chk("t5_held_act", 32'(shell_active), 1);
        chk("t5_held_x", 32'(ShellX), 224);
        keycode = 8'h00;
        tick();
        keycode = 8'h2C;
        tick();
        chk("t5_repress_x", 32'(ShellX), 224);
        chk("t5_repress_act", 32'(shell_active), 1);

        // Player 2 shooting down at an enemy three tiles below.
        Reset   = 1'b1;
        player  = 1'b0;
        keycode = 8'h00;
        OwnX    = 10'd576;
        OwnY    = 10'd32;
        EnemyX  = 10'd576;
        EnemyY  = 10'd128;
        tick();
        chk("t3_rst_facing", 32'(facing), 1);
        Reset   = 1'b0;
        keycode = 8'h28;
        tick();
        chk("t3_launch_act", 32'(shell_active), 1);
        chk("t3_launch_x", 32'(ShellX), 576);
        chk("t3_launch_y", 32'(ShellY), 64);
        keycode = 8'h00;
        ticks(4);
        chk("t3_adv_y", 32'(ShellY), 96);
        chk("t3_adv_hit", 32'(hit), 0);
        ticks(3);
        chk("t3_prehit", 32'(hit), 0);
        tick();
        chk("t3_hit", 32'(hit), 1);
        chk("t3_hit_act", 32'(shell_active), 0);
        chk("t3_hit_y", 32'(ShellY), 96);
        tick();
        chk("t3_hit_clear", 32'(hit), 0);

        // Enemy drives onto the shell's tile.
        Reset  = 1'b1;
        player = 1'b1;
        OwnX   = 10'd32;
        OwnY   = 10'd416;
        EnemyX = 10'd608;
        EnemyY = 10'd448;
        tick();
        Reset   = 1'b0;
        keycode = 8'h2C;
        tick();
        chk("t7_launch_y", 32'(ShellY), 384);
        keycode = 8'h00;
        EnemyX  = 10'd32;
        EnemyY  = 10'd384;
        tick();
        chk("t7_hit", 32'(hit), 1);
        chk("t7_act", 32'(shell_active), 0);
        tick();
        chk("t7_hit_clear", 32'(hit), 0);

        // Fly up off the top edge: stops at row 0 without a hit.
        Reset  = 1'b1;
        OwnX   = 10'd32;
        OwnY   = 10'd96;
        EnemyX = 10'd608;
        EnemyY = 10'd448;
        tick();
        Reset   = 1'b0;
        keycode = 8'h2C;
        tick();
        chk("t4_launch_y", 32'(ShellY), 64);
        keycode = 8'h00;
        ticks(4);
        chk("t4_y32", 32'(ShellY), 32);
        ticks(4);
        chk("t4_y0", 32'(ShellY), 0);
        chk("t4_y0_act", 32'(shell_active), 1);
        ticks(3);
        chk("t4_pre_act", 32'(shell_active), 1);
        tick();
        chk("t4_end_act", 32'(shell_active), 0);
        chk("t4_end_hit", 32'(hit), 0);
        chk("t4_end_y", 32'(ShellY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
